// File: rtl/mano_seq_pkg.sv
// Shared constants for the Mano basic-computer sequence counter.
// Optional interrupt cycle is enabled with macro MANO_SEQ_INTR_CYCLE_EN.
package mano_seq_pkg;

  localparam int SC_W   = 4;
  localparam int T_W    = 1 << SC_W;
  localparam int PH_W   = 3;

  // IR[14:12] value shared by register-reference and I/O instructions;
  // these never take an indirect cycle.
  localparam logic [2:0] OPC_RR_IO = 3'd7;

  typedef enum logic [PH_W-1:0] {
    PH_FETCH    = 3'd0,
    PH_DECODE   = 3'd1,
    PH_INDIRECT = 3'd2,
    PH_EXECUTE  = 3'd3,
    PH_INTR     = 3'd4,
    PH_HALT     = 3'd5
  } phase_t;

endpackage

// File: rtl/mano_seq_decoder.sv
// 4-to-16 one-hot decoder with enable: produces the T0..T15 timing signals.
module mano_seq_decoder
  import mano_seq_pkg::*;
(
  input  logic [SC_W-1:0] sel,
  input  logic            en,
  output logic [T_W-1:0]  y
);

  // One-hot decode, all-zero when disabled.
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/mano_sequencer.sv
// Mano basic-computer sequence counter and instruction-cycle phase tracker.
// Define MANO_SEQ_INTR_CYCLE_EN to include the interrupt cycle (R flag,
// RT0..RT2, intr_ack); otherwise INTR is unreachable.
module mano_sequencer
  import mano_seq_pkg::*;
(
  input  logic             clk_1hz,
  input  logic             reset,
  input  logic             fsm_clk_enable,
  input  logic             sc_clr,
  input  logic             hlt,
  input  logic             start,
  input  logic [2:0]       ir_opcode,
  input  logic             ir_i,
  input  logic             ien,
  input  logic             fgi,
  input  logic             fgo,
  output logic [T_W-1:0]   t,
  output logic [SC_W-1:0]  sc,
  output logic [PH_W-1:0]  phase,
  output logic             r_flag,
  output logic             intr_ack,
  output logic             instr_done,
  output logic             halted,
  output logic             sc_overflow
);

  phase_t state;
  logic   intr_req;

`ifdef MANO_SEQ_INTR_CYCLE_EN
  assign intr_req = ien & (fgi | fgo);
`else
  logic unused_intr_inputs;
  assign intr_req           = 1'b0;
  assign unused_intr_inputs = ^{ien, fgi, fgo};
`endif

  assign phase = state;

  mano_seq_decoder u_dec (
    .sel (sc),
    .en  (~halted),
    .y   (t)
  );

  // Sequencer state machine: sc, phase, flags and one-cycle pulses.
  always_ff @(posedge clk_1hz or negedge reset) begin
    if (!reset) begin
      sc          <= '0;
      state       <= PH_FETCH;
      r_flag      <= 1'b0;
      halted      <= 1'b0;
      sc_overflow <= 1'b0;
      intr_ack    <= 1'b0;
      instr_done  <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      intr_ack   <= 1'b0;
      if (fsm_clk_enable) begin
        if (halted) begin
          // Only start can leave HALT; sc_clr and hlt are ignored.
          if (start) begin
            halted <= 1'b0;
            state  <= PH_FETCH;
            sc     <= '0;
          end
        end else begin
          // Interrupt request is latched only after the fetch timing slots.
          if (intr_req && state != PH_INTR && sc > 4'd2) r_flag <= 1'b1;

          if (hlt) begin
            sc         <= '0;
            state      <= PH_HALT;
            halted     <= 1'b1;
            instr_done <= 1'b1;
          end else if (state == PH_INTR) begin
            // RT0..RT2, then back to fetch; sc_clr has no effect here.
            if (sc == 4'd2) begin
              sc       <= '0;
              r_flag   <= 1'b0;
              state    <= PH_FETCH;
              intr_ack <= 1'b1;
            end else begin
              sc <= sc + 4'd1;
            end
          end else if (sc_clr) begin
            sc         <= '0;
            state      <= r_flag ? PH_INTR : PH_FETCH;
            instr_done <= 1'b1;
          end else if (sc == 4'd15) begin
            sc          <= '0;
            sc_overflow <= 1'b1;
            state       <= PH_FETCH;
          end else begin
            sc <= sc + 4'd1;
            case (state)
              PH_FETCH:    if (sc == 4'd1) state <= PH_DECODE;
              PH_DECODE:   state <= (ir_opcode != OPC_RR_IO && ir_i) ? PH_INDIRECT
                                                                      : PH_EXECUTE;
              PH_INDIRECT: state <= PH_EXECUTE;
              default:     state <= state;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mano_sequencer.sv
// Self-checking bench for mano_sequencer: directed scenarios followed by
// randomized stimulus, all checked against a behavioural model.
module tb_mano_sequencer;

  logic        clk_1hz = 1'b0;
  logic        reset = 1'b0;
  logic        fsm_clk_enable = 1'b0, sc_clr = 1'b0, hlt = 1'b0, start = 1'b0;
  logic [2:0]  ir_opcode = 3'd7;
  logic        ir_i = 1'b0, ien = 1'b0, fgi = 1'b0, fgo = 1'b0;
  logic [15:0] t;
  logic [3:0]  sc;
  logic [2:0]  phase;
  logic        r_flag, intr_ack, instr_done, halted, sc_overflow;

  int checks = 0;
  int passes = 0;

  // model state: phase numbers FETCH0 DECODE1 INDIRECT2 EXECUTE3 INTR4 HALT5
  int m_sc, m_ph;
  bit m_r, m_halt, m_ovf, m_ack, m_done;

`ifdef MANO_SEQ_INTR_CYCLE_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif

  mano_sequencer dut (
    .clk_1hz(clk_1hz), .reset(reset), .fsm_clk_enable(fsm_clk_enable),
    .sc_clr(sc_clr), .hlt(hlt), .start(start), .ir_opcode(ir_opcode),
    .ir_i(ir_i), .ien(ien), .fgi(fgi), .fgo(fgo), .t(t), .sc(sc),
    .phase(phase), .r_flag(r_flag), .intr_ack(intr_ack),
    .instr_done(instr_done), .halted(halted), .sc_overflow(sc_overflow)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_t;
    exp_t = m_halt ? 16'h0 : (16'h1 << m_sc);
    chk({tag, ".sc"},     {28'd0, sc}, m_sc);
    chk({tag, ".phase"},  {29'd0, phase}, m_ph);
    chk({tag, ".t"},      {16'd0, t}, {16'd0, exp_t});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halt});
    chk({tag, ".ovf"},    {31'd0, sc_overflow}, {31'd0, m_ovf});
    chk({tag, ".r"},      {31'd0, r_flag}, {31'd0, m_r});
    chk({tag, ".ack"},    {31'd0, intr_ack}, {31'd0, m_ack});
    chk({tag, ".done"},   {31'd0, instr_done}, {31'd0, m_done});
  endtask

  task automatic model_reset();
    m_sc = 0; m_ph = 0; m_r = 0; m_halt = 0; m_ovf = 0; m_ack = 0; m_done = 0;
  endtask

  // Behavioural view of one clock edge with the current inputs.
  task automatic model_edge();
    bit nr;
    m_ack = 0; m_done = 0;
    if (!fsm_clk_enable) return;
    if (m_halt) begin
      if (start) begin m_halt = 0; m_ph = 0; m_sc = 0; end
      return;
    end
    nr = m_r;
    if (INTR_EN && m_ph != 4 && m_sc > 2 && ien && (fgi || fgo)) nr = 1;
    if (hlt) begin
      m_sc = 0; m_ph = 5; m_halt = 1; m_done = 1;
    end else if (m_ph == 4) begin
      if (m_sc == 2) begin m_sc = 0; nr = 0; m_ph = 0; m_ack = 1; end
      else m_sc++;
    end else if (sc_clr) begin
      m_sc = 0; m_ph = m_r ? 4 : 0; m_done = 1;
    end else if (m_sc == 15) begin
      m_sc = 0; m_ovf = 1; m_ph = 0;
    end else begin
      if (m_ph == 0 && m_sc == 1) m_ph = 1;
      else if (m_ph == 1) m_ph = (ir_opcode != 3'd7 && ir_i) ? 2 : 3;
      else if (m_ph == 2) m_ph = 3;
      m_sc++;
    end
    m_r = nr;
  endtask

  task automatic step(input string tag, input bit en, input bit clr, input bit h, input bit st);
    fsm_clk_enable = en; sc_clr = clr; hlt = h; start = st;
    @(posedge clk_1hz);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk_1hz);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk_1hz);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk_1hz);
    reset = 1'b1;

    // Basic instruction: clear at sc=5 ends it.
    ir_opcode = 3'd7; ir_i = 1'b0;
    step("adv1", 1, 0, 0, 0);
    chk("first_adv_sc", {28'd0, sc}, 32'd1);
    chk("first_adv_t", {16'd0, t}, 32'h2);
    for (int i = 0; i < 4; i++) step("basic", 1, 0, 0, 0);
    chk("basic_exec", {29'd0, phase}, 32'd3);
    step("basic_clr", 1, 1, 0, 0);
    chk("basic_done", {31'd0, instr_done}, 32'd1);
    step("basic_after", 1, 0, 0, 0);
    chk("done_pulse_len", {31'd0, instr_done}, 32'd0);

    // Indirect path with pulsed enables (sc is now 1).
    ir_opcode = 3'd3; ir_i = 1'b1;
    step("clr", 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step("ind_adv", 1, 0, 0, 0);
      step("ind_hold", 0, 0, 0, 0);
    end
    step("ind_exec", 1, 0, 0, 0);
    chk("ind_exec_sc", {28'd0, sc}, 32'd5);
    chk("ind_exec_ph", {29'd0, phase}, 32'd3);

    // 16 advances from sc=0 wrap back to 0 with sticky overflow.
    step("clr2", 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) step("wrap", 1, 0, 0, 0);
    chk("wrap_sc", {28'd0, sc}, 32'd0);
    chk("wrap_ovf", {31'd0, sc_overflow}, 32'd1);
    step("after_wrap", 1, 0, 0, 0);
    chk("ovf_sticky", {31'd0, sc_overflow}, 32'd1);

    // hlt beats sc_clr; start resumes.
    for (int i = 0; i < 3; i++) step("pre_hlt", 1, 0, 0, 0);
    step("hlt", 1, 1, 1, 0);
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_t", {16'd0, t}, 32'd0);
    chk("hlt_phase", {29'd0, phase}, 32'd5);
    step("halt_hold", 1, 1, 1, 0);
    step("start_noen", 0, 0, 0, 1);
    step("start", 1, 0, 0, 1);
    chk("start_halted", {31'd0, halted}, 32'd0);
    chk("start_sc", {28'd0, sc}, 32'd0);

`ifdef MANO_SEQ_INTR_CYCLE_EN
    async_reset("rst_intr");
    ir_opcode = 3'd7; ir_i = 1'b0;
    for (int i = 0; i < 4; i++) step("i_pre", 1, 0, 0, 0);
    ien = 1'b1; fgi = 1'b1;
    step("i_req", 1, 0, 0, 0);
    ien = 1'b0; fgi = 1'b0;
    chk("i_rflag", {31'd0, r_flag}, 32'd1);
    step("i_sc6", 1, 0, 0, 0);
    step("i_clr", 1, 1, 0, 0);
    chk("i_phase", {29'd0, phase}, 32'd4);
    step("i_rt1", 1, 1, 0, 0);
    step("i_rt2", 1, 0, 0, 0);
    step("i_ret", 1, 0, 0, 0);
    chk("i_ack", {31'd0, intr_ack}, 32'd1);
    chk("i_rclr", {31'd0, r_flag}, 32'd0);
    // enter INTR again and reset at RT1
    for (int i = 0; i < 3; i++) step("i2_pre", 1, 0, 0, 0);
    ien = 1'b1; fgo = 1'b1;
    step("i2_req", 1, 0, 0, 0);
    ien = 1'b0; fgo = 1'b0;
    step("i2_clr", 1, 1, 0, 0);
    step("i2_rt1", 1, 0, 0, 0);
    async_reset("rst_mid_intr");
`else
    for (int i = 0; i < 3; i++) step("mid_pre", 1, 0, 0, 0);
    async_reset("rst_mid_instr");
`endif

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      ir_opcode = 3'($urandom_range(0, 7));
      ir_i = 1'($urandom);
      ien = ($urandom_range(0, 3) == 0);
      fgi = 1'($urandom);
      fgo = 1'($urandom);
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
